// File: rtl/periph_arbiter_pkg.sv
// periph_arbiter_pkg -- shared definitions for the peripheral arbiter slice.
//   ID_W       : width of the source tag placed in the top bits of each word
//   FT_WORD_W  : width of the word handed to the FT601 controller
//   arb_state_e: arbiter FSM states
package periph_arbiter_pkg;

  localparam int ID_W      = 3;
  localparam int FT_WORD_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } arb_state_e;

endpackage

// File: rtl/periph_arbiter_if.sv
// periph_arbiter_if -- bundle between the peripheral FIFOs, the arbiter and the
// FT601 controller.
//   periph_valid          : per-source FWFT FIFO not empty
//   periph_data           : per-source head-of-FIFO payload
//   periph_ren            : one-hot pop strobe back to the sources
//   periph_data_available : periph_word holds a valid word
//   periph_word           : {source ID, payload}
//   read_periph_data      : controller takes periph_word this cycle
// Modports: master = arbiter side, slave = sources/controller side.
interface periph_arbiter_if #(
  parameter int NUM_PERIPHS = 4,
  parameter int PAYLOAD_W   = 29
);
  import periph_arbiter_pkg::*;

  logic [NUM_PERIPHS-1:0]                periph_valid;
  logic [NUM_PERIPHS-1:0][PAYLOAD_W-1:0] periph_data;
  logic [NUM_PERIPHS-1:0]                periph_ren;
  logic                                  periph_data_available;
  logic [FT_WORD_W-1:0]                  periph_word;
  logic                                  read_periph_data;

  modport master (
    input  periph_valid, periph_data, read_periph_data,
    output periph_ren, periph_data_available, periph_word
  );

  modport slave (
    output periph_valid, periph_data, read_periph_data,
    input  periph_ren, periph_data_available, periph_word
  );

endinterface

// File: rtl/periph_arbiter_rr_priority_pick.sv
// rr_priority_pick -- combinational round-robin picker.
//   req  : request vector (one bit per source)
//   ptr  : highest-priority index this round (must be < N)
//   any  : at least one request is set
//   pick : first set request at or after ptr, wrapping modulo N
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] pick
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [SEL_W:0] sum;

  // Rotate so that bit 0 is the source at ptr; the first set bit of the
  // rotated vector is then the distance from ptr to the winner.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N-1:0];

  // NOTE: every output of this block gets a default first, so no path through
  // the loop can leave a value unassigned and infer a latch.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && req_rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (SEL_W+1)'(i);
        if (sum >= (SEL_W+1)'(N)) sum = sum - (SEL_W+1)'(N);
        pick = sum[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/periph_arbiter.sv
// periph_arbiter -- round-robin arbiter draining NUM_PERIPHS FWFT FIFOs into a
// single tagged 32-bit word stream for an FT601 controller.
//   clk  : single clock
//   rst  : synchronous, active-high reset
//   bus  : periph_arbiter_if.master (valid/data/ren toward the sources,
//          data_available/word/read toward the controller)
// Build option: define ARB_BURST_LIMIT_EN to end each grant after BURST_LEN
// pops; otherwise a grant lasts until its source drains.
module periph_arbiter
  import periph_arbiter_pkg::*;
#(
  parameter int NUM_PERIPHS = 4,
  parameter int PAYLOAD_W   = 29,
  parameter int BURST_LEN   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  periph_arbiter_if.master         bus
);

  localparam int SEL_W = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1;

  if (PAYLOAD_W + ID_W != FT_WORD_W) begin : g_bad_payload_w
    $error("periph_arbiter: PAYLOAD_W + ID_W must equal FT_WORD_W");
  end
  if (NUM_PERIPHS < 2 || NUM_PERIPHS > 8) begin : g_bad_num_periphs
    $error("periph_arbiter: NUM_PERIPHS must be in 2..8");
  end
  if (BURST_LEN < 2 || BURST_LEN > 256) begin : g_bad_burst_len
    $error("periph_arbiter: BURST_LEN must be in 2..256");
  end

  arb_state_e           state_q, state_d;
  logic [SEL_W-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 avail_q, avail_d;
  logic [FT_WORD_W-1:0] word_q, word_d;
  logic [NUM_PERIPHS-1:0] ren;
  logic                 load_en;
  logic                 end_grant;
  logic                 pick_any;
  logic [SEL_W-1:0]     pick_idx;
`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  rr_priority_pick #(
    .N     (NUM_PERIPHS),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (bus.periph_valid),
    .ptr  (rr_ptr_q),
    .any  (pick_any),
    .pick (pick_idx)
  );

  // The output register can take a new word whenever it is empty or being
  // drained this very cycle.
  assign load_en = !avail_q || bus.read_periph_data;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    avail_d   = avail_q;
    word_d    = word_q;
    ren       = '0;
    end_grant = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d     = cnt_q;
`endif

    // Consumed with no refill; a load below takes precedence.
    if (avail_q && bus.read_periph_data) avail_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_STREAM;
`ifdef ARB_BURST_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_STREAM: begin
        if (load_en) begin
          if (bus.periph_valid[grant_q]) begin
            ren[grant_q] = 1'b1;
            word_d       = {ID_W'(grant_q), bus.periph_data[grant_q]};
            avail_d      = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BURST_LEN - 1)) end_grant = 1'b1;
`endif
          end else begin
            end_grant = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_grant) begin
      state_d  = ST_IDLE;
      rr_ptr_d = (grant_q == SEL_W'(NUM_PERIPHS - 1)) ? '0 : grant_q + 1'b1;
    end

    // Reset is synchronous, so the pop strobe must be masked combinationally
    // to keep a source from losing a word during the reset cycle.
    if (rst) ren = '0;
  end

  assign bus.periph_ren            = ren;
  assign bus.periph_data_available = avail_q;
  assign bus.periph_word           = word_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      avail_q  <= 1'b0;
      word_q   <= '0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      avail_q  <= avail_d;
      word_q   <= word_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 SHALL have parameter NUM_PERIPHS, default 4, number of peripheral sources (2..8).
REQ-002 SHALL have parameter PAYLOAD_W, default 29, payload bits per peripheral word.
REQ-003 SHALL have parameter BURST_LEN, default 8, maximum words per grant (2..256).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port periph_valid  input  NUM_PERIPHS  per-source first-word-fall-through FIFO not empty.
REQ-007 SHALL have port periph_data  input  NUM_PERIPHS x PAYLOAD_W  per-source head-of-FIFO payload.
REQ-008 SHALL have port periph_ren  output  NUM_PERIPHS  one-hot pop strobe to sources.
REQ-009 SHALL have port periph_data_available  output  1  output word valid toward FT601 controller.
REQ-010 SHALL have port periph_word  output  32  tagged word toward FT601 controller.
REQ-011 SHALL have port read_periph_data  input  1  controller consumes periph_word this cycle.

Function
REQ-012 SHALL form periph_word as {3-bit source ID, 29-bit payload}; PAYLOAD_W+3 SHALL equal 32 (elaboration error otherwise).
REQ-013 SHALL implement FSM states IDLE and STREAM.
REQ-014 In IDLE, SHALL pick the first asserted periph_valid at or after rr_ptr (wrapping modulo NUM_PERIPHS), latch it as grant, zero the burst count and enter STREAM next cycle; SHALL stay in IDLE with no pops when no source is valid.
REQ-015 SHALL define load_en = !periph_data_available || read_periph_data (single output register, full-throughput).
REQ-016 In STREAM, when load_en && periph_valid[grant], SHALL pulse periph_ren[grant] that cycle, register {grant, payload} into periph_word, set periph_data_available and increment the burst count.
REQ-017 When read_periph_data && periph_data_available && no load occurs, SHALL clear periph_data_available next cycle.
REQ-018 SHALL ignore read_periph_data while periph_data_available is low.
REQ-019 periph_ren SHALL be at most one-hot, never asserted in IDLE, never asserted for a source whose periph_valid is low.
REQ-020 In STREAM, SHALL return to IDLE when load_en && !periph_valid[grant] (source drained), or on the pop that makes the burst count reach BURST_LEN (when enabled, REQ-026).
REQ-021 On every STREAM->IDLE transition, SHALL set rr_ptr = (grant+1) mod NUM_PERIPHS.
REQ-022 Latency: periph_valid rising in IDLE SHALL yield periph_data_available high two cycles later.
REQ-023 SHALL sustain one word per cycle within a burst while read_periph_data is held high.
REQ-024 periph_word SHALL remain stable while periph_data_available is high and read_periph_data is low.

Reset
REQ-025 On rst: state=IDLE, rr_ptr=0, grant=0, burst count=0, periph_data_available=0, periph_word=0, periph_ren=0; a word held in the output register SHALL be discarded; reset SHALL override all other inputs the same cycle.

Configuration
REQ-026 With ARB_BURST_LIMIT_EN defined, a grant SHALL end after BURST_LEN pops; without it, the burst count SHALL be absent and a grant SHALL be held until the source drains.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the 3-bit ID width constant and the 32-bit FT601 word width constant.
REQ-028 SHALL instantiate one sub-module, rr_priority_pick, computing the next grant from request vector and rr_ptr combinationally.

Verification
REQ-029 Reset mid-burst: grant=2, periph_data_available=1, assert rst -> next cycle periph_data_available=0, periph_ren=0, rr_ptr=0.
REQ-030 Single source: periph_valid=4'b0010 holding 3 words, read_periph_data=1 -> words 0x2000_0000|payload (ID 1) on 3 consecutive cycles starting 2 cycles after valid, then IDLE.
REQ-031 Round-robin: all four sources valid continuously, macro defined, BURST_LEN=8 -> bursts of 8 words with IDs 0,1,2,3,0 in order.
REQ-032 Backpressure: read_periph_data low for 5 cycles mid-burst -> periph_word unchanged, no periph_ren pulses, resumption without loss or duplication.
REQ-033 Wrap: rr_ptr=3, only source 0 valid -> grant=0, first word ID 0.
REQ-034 Macro undefined: source 1 holds 20 words -> one uninterrupted 20-word grant despite other sources valid.
